// File: rtl/ascii_text_buffer_writer_if.sv
// ascii_text_buffer_writer_if: upstream character handshake, buffer write port and status of the text buffer writer.
interface ascii_text_buffer_writer_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W = 12
);
  logic [7:0] ascii_in;
  logic ascii_valid;
  logic ascii_ready;
  logic clear_req;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic [CNT_W-1:0] char_count;
  logic busy;
  modport master (
    output ascii_in, ascii_valid, clear_req,
    input ascii_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, char_count, busy
  );
  modport slave (
    input ascii_in, ascii_valid, clear_req,
    output ascii_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, char_count, busy
  );
endinterface

// File: rtl/ascii_text_buffer_writer.sv
// ascii_text_buffer_writer: writes a character stream into a text buffer with cursor and clears.
// Define TEXTBUF_BACKSPACE_EN to make 0x08 erase the previous cell.
module ascii_text_buffer_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ADDR_W = 12,
  parameter int CNT_W = 12
) (
  input logic clk,
  input logic reset_n,
  ascii_text_buffer_writer_if.slave bus
);
  localparam int N = ROWS * COLS;
  typedef enum logic [1:0] {CLEAR, READY, WRITE} state_t;
  state_t state, nxt;
  logic [ADDR_W:0] idx, idx_n, ca;
  logic [6:0] col, col_n;
  logic [4:0] row, row_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic pend, pend_n, we_n, hs, last_col, last_row, printable;
  logic [ADDR_W-1:0] wa_n, cur_addr;
  logic [7:0] wd_n, ch;
  assign ch = bus.ascii_in;
  assign hs = state == READY && bus.ascii_valid;
  assign last_col = col == 7'(COLS - 1);
  assign last_row = row == 5'(ROWS - 1);
  assign printable = ch >= 8'h20 && ch <= 8'h7e;
  assign cur_addr = ADDR_W'(int'(row) * COLS + int'(col));
  // a clear entered from READY/WRITE starts at address 0 on its first cycle
  assign ca = state == CLEAR ? idx : '0;
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;
  assign bus.char_count = cnt;
  always_comb begin
    nxt = state;
    idx_n = idx;
    col_n = col;
    row_n = row;
    cnt_n = cnt;
    pend_n = pend;
    we_n = 1'b0;
    wa_n = bus.wr_addr;
    wd_n = bus.wr_data;
    case (state)
      CLEAR: if (idx == (ADDR_W + 1)'(N)) begin
        nxt = READY;
        col_n = '0;
        row_n = '0;
        cnt_n = '0;
      end
      READY: if (hs && printable) begin
        nxt = WRITE;
        we_n = 1'b1;
        wa_n = cur_addr;
        wd_n = ch;
        cnt_n = &cnt ? cnt : cnt + 1'b1;
        col_n = last_col ? '0 : col + 7'd1;
        row_n = last_col ? (last_row ? '0 : row + 5'd1) : row;
        pend_n = bus.clear_req || (last_col && last_row);
      end else if (hs && ch == 8'h0a) begin
        col_n = '0;
        row_n = last_row ? '0 : row + 5'd1;
        nxt = (last_row || bus.clear_req) ? CLEAR : READY;
`ifdef TEXTBUF_BACKSPACE_EN
      end else if (hs && ch == 8'h08 && (col != '0 || row != '0)) begin
        nxt = WRITE;
        we_n = 1'b1;
        wa_n = cur_addr - 1'b1;
        wd_n = 8'h20;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
        col_n = col == '0 ? 7'(COLS - 1) : col - 7'd1;
        row_n = col == '0 ? row - 5'd1 : row;
        pend_n = bus.clear_req;
`endif
      end else begin
        col_n = hs && ch == 8'h0d ? '0 : col;
        nxt = bus.clear_req ? CLEAR : READY;
      end
      WRITE: begin
        nxt = (pend || bus.clear_req) ? CLEAR : READY;
        pend_n = 1'b0;
      end
      default: nxt = CLEAR;
    endcase
    if (nxt == CLEAR) begin
      we_n = 1'b1;
      wa_n = ca[ADDR_W-1:0];
      wd_n = 8'h20;
      idx_n = ca + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= CLEAR;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      col <= '0;
      row <= '0;
      cnt <= '0;
      pend <= 1'b0;
      bus.ascii_ready <= 1'b0;
      bus.busy <= 1'b1;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= 8'h20;
    end else begin
      idx <= idx_n;
      col <= col_n;
      row <= row_n;
      cnt <= cnt_n;
      pend <= pend_n;
      bus.ascii_ready <= nxt == READY;
      bus.busy <= nxt == CLEAR;
      bus.wr_en <= we_n;
      bus.wr_addr <= wa_n;
      bus.wr_data <= wd_n;
    end
endmodule

// File: tb/tb_ascii_text_buffer_writer.sv
// tb_ascii_text_buffer_writer: directed and random character streams checked against a linear-position screen model.
module tb_ascii_text_buffer_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int ADDR_W = 12;
  localparam int CNT_W = 12;
  localparam int N = ROWS * COLS;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int pos = 0;
  int cnt = 0;
  ascii_text_buffer_writer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  ascii_text_buffer_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_check(input bit first_now);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      if (i > 0 || !first_now) @(negedge clk);
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(i) || bus.wr_data !== 8'h20 ||
          bus.busy !== 1'b1 || bus.ascii_ready !== 1'b0) bad++;
    end
    chk("clear_seq_bad_cycles", 32'(bad), 0);
    @(negedge clk);
    chk("clear_done_ready", 32'(bus.ascii_ready), 1);
    chk("clear_done_busy", 32'(bus.busy), 0);
    chk("clear_done_wr_en", 32'(bus.wr_en), 0);
    chk("clear_done_col", 32'(bus.cursor_col), 0);
    chk("clear_done_row", 32'(bus.cursor_row), 0);
    chk("clear_done_count", 32'(bus.char_count), 0);
    pos = 0;
    cnt = 0;
  endtask
  task automatic clear_only();
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    @(negedge clk);
    clear_check(1'b1);
  endtask
  task automatic send(input logic [7:0] c, input bit cr);
    bit wr, clr;
    int waddr, t;
    logic [7:0] wdata;
    t = 0;
    while (!bus.ascii_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ascii_ready) begin
      chk("ready_timeout", 32'(bus.ascii_ready), 1);
      return;
    end
    bus.ascii_in = c;
    bus.ascii_valid = 1'b1;
    bus.clear_req = cr;
    @(posedge clk);
    #1 bus.ascii_valid = 1'b0;
    bus.clear_req = 1'b0;
    wr = 1'b0;
    clr = cr;
    waddr = 0;
    wdata = 8'h00;
    if (c >= 8'h20 && c <= 8'h7e) begin
      wr = 1'b1;
      waddr = pos;
      wdata = c;
      pos++;
      cnt = cnt < MAXC ? cnt + 1 : cnt;
      if (pos == N) clr = 1'b1;
    end else if (c == 8'h0a) begin
      pos = (pos / COLS + 1) * COLS;
      if (pos == N) clr = 1'b1;
    end else if (c == 8'h0d) begin
      pos -= pos % COLS;
`ifdef TEXTBUF_BACKSPACE_EN
    end else if (c == 8'h08 && pos > 0) begin
      wr = 1'b1;
      pos--;
      waddr = pos;
      wdata = 8'h20;
      if (cnt > 0) cnt--;
`endif
    end
    @(negedge clk);
    if (wr) begin
      chk("write_en", 32'(bus.wr_en), 1);
      chk("write_addr", 32'(bus.wr_addr), waddr);
      chk("write_data", 32'(bus.wr_data), 32'(wdata));
      chk("ready_low_in_write", 32'(bus.ascii_ready), 0);
    end
    if (clr) clear_check(!wr);
    else begin
      if (!wr) begin
        chk("no_write", 32'(bus.wr_en), 0);
        chk("ready_after_ctrl", 32'(bus.ascii_ready), 1);
      end
      chk("cursor_col", 32'(bus.cursor_col), pos % COLS);
      chk("cursor_row", 32'(bus.cursor_row), pos / COLS);
      chk("char_count", 32'(bus.char_count), cnt);
    end
  endtask
  function automatic logic [7:0] rnd_char();
    int r = $urandom_range(0, 15);
    if (r == 0) return 8'h0a;
    if (r == 1) return 8'h0d;
    if (r == 2) return 8'h08;
    if (r == 3) return 8'($urandom_range(0, 31));
    return 8'($urandom_range(32, 126));
  endfunction
  initial begin
    bus.ascii_in = 8'h00;
    bus.ascii_valid = 1'b0;
    bus.clear_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ascii_ready), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'h20);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_col", 32'(bus.cursor_col), 0);
    chk("rst_row", 32'(bus.cursor_row), 0);
    chk("rst_count", 32'(bus.char_count), 0);
    reset_n = 1'b1;
    clear_check(1'b0);
    send(8'h41, 1'b0);
    @(negedge clk);
    chk("ready_back_after_write", 32'(bus.ascii_ready), 1);
    clear_only();
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h0a, 1'b0);
    send(8'h43, 1'b0);
    chk("seq_row", 32'(bus.cursor_row), 1);
    chk("seq_col", 32'(bus.cursor_col), 1);
    clear_only();
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)), 1'b0);
    chk("row_after_80", 32'(bus.cursor_row), 1);
    chk("col_after_80", 32'(bus.cursor_col), 0);
    send(8'h07, 1'b0);
    send(8'h0d, 1'b0);
    send(8'h5a, 1'b1);
    send(8'h41, 1'b0);
    send(8'h08, 1'b0);
`ifdef TEXTBUF_BACKSPACE_EN
    chk("bs_col", 32'(bus.cursor_col), 0);
    chk("bs_count", 32'(bus.char_count), 0);
`else
    chk("bs_col", 32'(bus.cursor_col), 1);
    chk("bs_count", 32'(bus.char_count), 1);
`endif
    send(8'h08, 1'b0);
    send(8'h0d, 1'b1);
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1 bus.clear_req = 1'b0;
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midclear_rst_busy", 32'(bus.busy), 1);
    chk("midclear_rst_wr_en", 32'(bus.wr_en), 0);
    chk("midclear_rst_addr", 32'(bus.wr_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_check(1'b0);
    for (int i = 0; i < 300; i++) send(rnd_char(), $urandom_range(0, 79) == 0);
    clear_only();
    for (int i = 0; i < N; i++) send(8'($urandom_range(32, 126)), 1'b0);
    for (int i = 0; i < ROWS; i++) send(8'h0a, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascii_text_buffer_writer.md
Name: ascii_text_buffer_writer

Overview:
- Consumes the character stream from the ASCII generator stage and writes it into the character-cell text buffer that the VGA text renderer reads.
- Tracks a row/column cursor and interprets control characters.
- Clears the buffer to spaces on reset, on request, and when the screen fills.
- Exposes a ready/valid handshake upstream and a single-port write interface downstream.

Parameters:
- COLS, 80, character columns per row (640 px / 8 px glyph)
- ROWS, 30, character rows (480 px / 16 px glyph)
- ADDR_W, 12, buffer address width; must satisfy ROWS*COLS <= 2**ADDR_W
- CNT_W, 12, width of char_count

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ascii_in  in  8  character from the generator stage
- ascii_valid  in  1  ascii_in is valid this cycle
- ascii_ready  out  1  block accepts a character this cycle
- clear_req  in  1  one-cycle pulse requesting a full-screen clear
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer address, row*COLS+col
- wr_data  out  8  character to write
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- char_count  out  CNT_W  printable characters written since the last clear, saturating
- busy  out  1  high while in CLEAR

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low (reset_n).
- All outputs are registered.
- Reset values: ascii_ready=0, wr_en=0, wr_addr=0, wr_data=0x20, cursor_col=0, cursor_row=0, char_count=0, busy=1, state=CLEAR, clear index=0.
- Reset assertion mid-operation aborts immediately to these values; a partial clear restarts from address 0.
- States: CLEAR, READY, WRITE.
- CLEAR:
  - Each cycle: wr_en=1, wr_data=0x20, wr_addr=index; index increments.
  - After writing address ROWS*COLS-1 (2400 cycles at defaults), go to READY.
  - On exit: cursor=(0,0), char_count=0, busy=0.
  - ascii_ready=0 throughout; clear_req is ignored.
- READY:
  - ascii_ready=1; a handshake is ascii_valid && ascii_ready.
  - clear_req without a handshake goes to CLEAR.
  - If clear_req coincides with a handshake, the character is processed first, then CLEAR.
  - Printable character (0x20..0x7E):
    - Go to WRITE.
    - Next cycle: wr_en=1, wr_addr=cursor address, wr_data=character.
    - char_count increments, saturating at 2**CNT_W-1.
    - Cursor advances: col+1; at col=COLS-1, col becomes 0 and row increments.
  - 0x0A (newline): col=0, row+1. No write. ascii_ready stays 1.
  - 0x0D (carriage return): col=0. No write.
  - Any other code: dropped, no state change.
- Screen full:
  - A row increment from row ROWS-1, whether by wrap or newline, enters CLEAR after any pending write completes.
  - Write-then-clear order: the last cell is written, then overwritten by the clear.
- WRITE: lasts one cycle, with ascii_ready=0; then READY, or CLEAR if a full-screen or clear request is pending.
- Throughput: one printable character per 2 cycles; control characters 1 per cycle.
- Latency: handshake to wr_en is 1 cycle.
- wr_en is never high in READY.
- ascii_in is ignored while ascii_ready=0; upstream must hold the character until the handshake.

Optional Feature:
- Macro: TEXTBUF_BACKSPACE_EN
- Defined:
  - 0x08 moves the cursor back one cell and writes 0x20 there (a one-cycle WRITE); char_count decrements unless already 0.
  - At col=0 the cursor moves to (row-1, COLS-1).
  - At (0,0) the character is ignored.
- Undefined: 0x08 is dropped like other non-printables, and no backspace logic is synthesized.

Test Plan:
- Release reset_n -> exactly 2400 consecutive wr_en cycles, wr_addr 0..2399, wr_data 0x20, busy=1; then ascii_ready=1, busy=0.
- Send 0x41 -> next cycle wr_en=1, wr_addr=0, wr_data=0x41; cursor_col=1, char_count=1; ascii_ready low for exactly 1 cycle.
- Send 0x41, 0x42, 0x0A, 0x43 -> writes at addresses 0 and 1; no write for 0x0A; 0x43 written at address 80; cursor ends at (1,1).
- Send 80 printable characters starting at (0,0) -> last write at address 79, cursor=(1,0). Send 0x07 -> no write, cursor unchanged.
- Send 2400 printable characters -> final write at address 2399, then busy=1 and a 2400-cycle clear, then cursor=(0,0), char_count=0. Also pulse reset_n low mid-clear -> clear restarts at address 0.
- With TEXTBUF_BACKSPACE_EN: send 0x41, 0x08 -> writes 0x41 at address 0, then 0x20 at address 0; cursor=(0,0), char_count=0. Without the macro: 0x08 gives no write.
